// File: rtl/counter8_checker.sv
// Monitor for the 8-state display counter: decodes the active-low segment
// pattern, checks it against the binary count and tracks the mod-8 sequence.
module counter8_checker #(
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [2:0]        iQ,
  input  logic [6:0]        iDisplay,
  output logic              oLocked,
  output logic              oErr,
  output logic              oResync,
  output logic              oSegErr,
  output logic [ERR_W-1:0]  oErrCnt,
  output logic [WRAP_W-1:0] oWrapCnt
);

  // state     | meaning
  // ST_SYNC   | counting consecutive good increments towards lock
  // ST_LOCKED | sequence trusted; deviations are errors or resyncs
  typedef enum logic {ST_SYNC = 1'b0, ST_LOCKED = 1'b1} state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_N);

  state_t            state_q, state_d;
  logic [3:0]        good_q, good_d;
  logic [2:0]        prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic              err_q, err_d;
  logic              resync_q, resync_d;
  logic              seg_err_q, seg_err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic       seg_valid;
  logic [2:0] seg_digit;
  logic [2:0] prev_inc;
  logic       seg_ok, seq_ok, good_step;
  logic       resync_hit, err_hit, wrap_hit;

  always_comb begin
    seg_valid = 1'b1;
    seg_digit = 3'd0;
    case (iDisplay)
      7'h40:   seg_digit = 3'd0;
      7'h79:   seg_digit = 3'd1;
      7'h24:   seg_digit = 3'd2;
      7'h30:   seg_digit = 3'd3;
      7'h19:   seg_digit = 3'd4;
      7'h12:   seg_digit = 3'd5;
      7'h02:   seg_digit = 3'd6;
      7'h78:   seg_digit = 3'd7;
      default: seg_valid = 1'b0;
    endcase
  end

  // 3-bit sum so that 7 + 1 wraps to 0
  assign prev_inc  = prev_q + 3'd1;
  assign seg_ok    = seg_valid && (seg_digit == iQ);
  assign seq_ok    = prev_valid_q && (iQ == prev_inc);
  assign good_step = seg_ok && seq_ok;

  assign resync_hit = (state_q == ST_LOCKED) && !good_step && seg_ok && (iQ == 3'd0);
  assign err_hit    = (state_q == ST_LOCKED) && !good_step && !resync_hit;
  assign wrap_hit   = (state_q == ST_LOCKED) && good_step && (prev_q == 3'd7);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      good_q       <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      err_q        <= 1'b0;
      resync_q     <= 1'b0;
      seg_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      wrap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      err_q        <= err_d;
      resync_q     <= resync_d;
      seg_err_q    <= seg_err_d;
      err_cnt_q    <= err_cnt_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      ST_SYNC: begin
        if (good_step) begin
          good_d = good_q + 4'd1;
          if (good_d == LOCK_CNT) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end
        end else begin
          good_d = '0;
        end
      end
      ST_LOCKED: begin
        if (err_hit) begin
          state_d = ST_SYNC;
          good_d  = '0;
        end
      end
      default: begin
        state_d = ST_SYNC;
        good_d  = '0;
      end
    endcase
  end

  always_comb begin
    prev_d       = iQ;
    prev_valid_d = 1'b1;
    err_d        = err_hit;
    resync_d     = resync_hit;
    seg_err_d    = seg_err_q | !seg_ok;
    err_cnt_d    = err_cnt_q;
    wrap_cnt_d   = wrap_cnt_q;
    if (err_hit && (err_cnt_q != {ERR_W{1'b1}}))
      err_cnt_d = err_cnt_q + ERR_W'(1);
    if (wrap_hit)
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
  end

  assign oLocked  = (state_q == ST_LOCKED);
  assign oErr     = err_q;
  assign oResync  = resync_q;
  assign oSegErr  = seg_err_q;
  assign oErrCnt  = err_cnt_q;
  assign oWrapCnt = wrap_cnt_q;

endmodule

// File: tb/tb_counter8_checker.sv
// Bench for counter8_checker: directed vector table, hand-written corner
// sequences and random traffic against a behavioural model.
module tb_counter8_checker;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] iQ = 3'd0;
  logic [6:0] iDisplay = 7'h40;

  logic       lk1, er1, rs1, sg1;
  logic [7:0] ec1, wc1;
  logic       lk2, er2, rs2, sg2;
  logic [1:0] ec2;
  logic [7:0] wc2;

  counter8_checker dut (
    .CLK(CLK), .rst(rst), .iQ(iQ), .iDisplay(iDisplay),
    .oLocked(lk1), .oErr(er1), .oResync(rs1), .oSegErr(sg1),
    .oErrCnt(ec1), .oWrapCnt(wc1)
  );

  counter8_checker #(.ERR_W(2)) dut_sat (
    .CLK(CLK), .rst(rst), .iQ(iQ), .iDisplay(iDisplay),
    .oLocked(lk2), .oErr(er2), .oResync(rs2), .oSegErr(sg2),
    .oErrCnt(ec2), .oWrapCnt(wc2)
  );

  always #5 CLK = ~CLK;

  logic [6:0] seg_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  int checks = 0;
  int failures = 0;

  // behavioural reference
  int m_locked, m_good, m_prev, m_pv, m_err, m_rs, m_seg, m_errs, m_wrap;

  task automatic model_reset();
    m_locked = 0; m_good = 0; m_prev = 0; m_pv = 0;
    m_err = 0; m_rs = 0; m_seg = 0; m_errs = 0; m_wrap = 0;
  endtask

  task automatic model_step(input int r, input int q, input logic [6:0] d);
    int digit;
    bit segok, seqok;
    if (r != 0) begin
      model_reset();
      return;
    end
    digit = -1;
    for (int i = 0; i < 8; i++) if (seg_tab[i] == d) digit = i;
    segok = (digit == q);
    seqok = (m_pv != 0) && (q == (m_prev + 1) % 8);
    m_err = 0;
    m_rs = 0;
    if (!segok) m_seg = 1;
    if (m_locked == 0) begin
      if (segok && seqok) begin
        m_good++;
        if (m_good == 2) begin m_locked = 1; m_good = 0; end
      end else m_good = 0;
    end else if (segok && seqok) begin
      if (m_prev == 7) m_wrap = (m_wrap + 1) % 256;
    end else if (segok && q == 0) begin
      m_rs = 1;
    end else begin
      m_err = 1; m_errs++; m_good = 0; m_locked = 0;
    end
    m_prev = q;
    m_pv = 1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("locked", int'(lk1), m_locked);
    chk("err", int'(er1), m_err);
    chk("resync", int'(rs1), m_rs);
    chk("segerr", int'(sg1), m_seg);
    chk("errcnt", int'(ec1), (m_errs > 255) ? 255 : m_errs);
    chk("wrapcnt", int'(wc1), m_wrap);
    chk("sat_locked", int'(lk2), m_locked);
    chk("sat_errcnt", int'(ec2), (m_errs > 3) ? 3 : m_errs);
  endtask

  // drive one edge, advance the model, sample 1 time unit after the edge
  task automatic step(input int r, input int q, input logic [6:0] d);
    rst = r[0];
    iQ = q[2:0];
    iDisplay = d;
    @(posedge CLK);
    model_step(r, q, d);
    #1;
    check_model();
  endtask

  typedef struct {
    bit r; int q; logic [6:0] d;
    int lk, er, rs, sg, ec, wr;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input bit r, input int q, input int lk, input int er,
                      input int rs, input int sg, input int ec, input int wr);
    vec_t v;
    v.r = r; v.q = q; v.d = seg_tab[q];
    v.lk = lk; v.er = er; v.rs = rs; v.sg = sg; v.ec = ec; v.wr = wr;
    vecs.push_back(v);
  endtask

  initial begin
    int q;
    int rv;
    logic [6:0] d;

    // clean count from reset: lock after 3rd edge, wraps after each 7->0
    addv(1, 0, 0, 0, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 7; i++) addv(0, i, 1, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 7; i++) addv(0, i, 1, 0, 0, 0, 0, 1);
    addv(0, 0, 1, 0, 0, 0, 0, 2);
    // counter reset mid-count: 3,4,5,0 -> resync, no error
    for (int i = 1; i <= 5; i++) addv(0, i, 1, 0, 0, 0, 0, 2);
    addv(0, 0, 1, 0, 1, 0, 0, 2);
    addv(0, 1, 1, 0, 0, 0, 0, 2);
    // skipped count 2,3,5 -> error, relock after 6,7
    addv(0, 2, 1, 0, 0, 0, 0, 2);
    addv(0, 3, 1, 0, 0, 0, 0, 2);
    addv(0, 5, 0, 1, 0, 0, 1, 2);
    addv(0, 6, 0, 0, 0, 0, 1, 2);
    addv(0, 7, 1, 0, 0, 0, 1, 2);
    addv(0, 0, 1, 0, 0, 0, 1, 3);

    model_reset();
    foreach (vecs[i]) begin
      step(int'(vecs[i].r), vecs[i].q, vecs[i].d);
      chk($sformatf("vec%0d_locked", i), int'(lk1), vecs[i].lk);
      chk($sformatf("vec%0d_err", i), int'(er1), vecs[i].er);
      chk($sformatf("vec%0d_resync", i), int'(rs1), vecs[i].rs);
      chk($sformatf("vec%0d_segerr", i), int'(sg1), vecs[i].sg);
      chk($sformatf("vec%0d_errcnt", i), int'(ec1), vecs[i].ec);
      chk($sformatf("vec%0d_wrapcnt", i), int'(wc1), vecs[i].wr);
    end

    // segment mismatch while locked: iQ=4 shown as 5
    step(0, 1, seg_tab[1]);
    step(0, 2, seg_tab[2]);
    step(0, 3, seg_tab[3]);
    step(0, 4, 7'h12);
    chk("mismatch_err", int'(er1), 1);
    chk("mismatch_segerr", int'(sg1), 1);
    chk("mismatch_errcnt", int'(ec1), 2);
    step(0, 5, seg_tab[5]);
    chk("mismatch_err_once", int'(er1), 0);
    step(0, 6, seg_tab[6]);
    chk("mismatch_relock", int'(lk1), 1);
    for (int i = 7; i <= 10; i++) step(0, i % 8, seg_tab[i % 8]);
    chk("segerr_sticky", int'(sg1), 1);

    // invalid pattern 7F, five errors against the ERR_W=2 instance
    step(1, 0, seg_tab[0]);
    chk("rst_segerr", int'(sg1), 0);
    step(0, 0, seg_tab[0]);
    step(0, 1, seg_tab[1]);
    step(0, 2, seg_tab[2]);
    q = 2;
    for (int n = 1; n <= 5; n++) begin
      q = (q + 1) % 8;
      step(0, q, 7'h7F);
      chk($sformatf("sat_err%0d", n), int'(ec2), (n > 3) ? 3 : n);
      chk($sformatf("sat_pulse%0d", n), int'(er2), 1);
      q = (q + 1) % 8;
      step(0, q, seg_tab[q]);
      q = (q + 1) % 8;
      step(0, q, seg_tab[q]);
    end
    chk("sat_hold", int'(ec2), 3);
    chk("sat_relocked", int'(lk2), 1);
    step(1, 0, 7'h7F);
    chk("rst_errcnt", int'(ec2), 0);
    chk("rst_segerr2", int'(sg2), 0);
    chk("rst_locked", int'(lk2), 0);
    chk("rst_err_suppressed", int'(er2), 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rv = int'($urandom_range(0, 99));
      if (rv < 2) begin
        step(1, int'($urandom_range(0, 7)), seg_tab[$urandom_range(0, 7)]);
      end else if (rv < 80) begin
        q = (m_prev + 1) % 8;
        step(0, q, seg_tab[q]);
      end else if (rv < 86) begin
        step(0, 0, seg_tab[0]);
      end else if (rv < 92) begin
        q = int'($urandom_range(0, 7));
        step(0, q, seg_tab[q]);
      end else if (rv < 96) begin
        q = (m_prev + 1) % 8;
        d = seg_tab[(q + 1 + int'($urandom_range(0, 6))) % 8];
        step(0, q, d);
      end else begin
        q = (m_prev + 1) % 8;
        d = 7'($urandom_range(0, 127));
        step(0, q, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter8_checker.md
# counter8_checker

Self-checking monitor that consumes the 3-bit count and 7-segment pattern produced by the 8-state display counter. It decodes the segment pattern back to a digit, confirms it matches the binary count, and tracks the expected mod-8 increment sequence. It reports lock, errors, legitimate counter resets and wrap-arounds. It sits beside the counter on the same clock, in simulation benches and in on-board self-test builds.

## Interface
- `LOCK_N`, default 2: number of consecutive good increments needed to enter LOCKED; legal range 1..15.
- `ERR_W`, default 8: width of the saturating error counter.
- `WRAP_W`, default 8: width of the wrap counter, which wraps modulo 2^WRAP_W.
- `CLK`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high; dominates all other inputs.
- `iQ`, in, 3: count from the counter under test.
- `iDisplay`, in, 7: segment pattern as {g,f,e,d,c,b,a}, active-low.
- `oLocked`, out, 1: high while the FSM is in LOCKED.
- `oErr`, out, 1: one-cycle pulse for each detected error.
- `oResync`, out, 1: one-cycle pulse for each accepted counter reset (jump to 0) while LOCKED.
- `oSegErr`, out, 1: sticky flag set by any invalid or mismatched segment pattern; cleared only by `rst`.
- `oErrCnt`, out, ERR_W: error count, saturating at all-ones.
- `oWrapCnt`, out, WRAP_W: count of 7→0 wraps seen while LOCKED.

## Operation
- **Decode table (hex):**
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7.
  - Any other pattern is invalid.
- **Per-cycle terms**, evaluated combinationally from the inputs and the `prev` register:
  - `seg_ok` = pattern valid and decoded digit equals `iQ`.
  - `seq_ok` = `prev_valid` and `iQ == (prev + 1) mod 8`, using 3-bit wrap arithmetic (7+1 = 0).
- **Every non-reset edge:** `prev` ← `iQ` and `prev_valid` ← 1.
- **States:** SYNC and LOCKED.
- **SYNC:**
  - If `seg_ok && seq_ok`, `good` increments. When `good` reaches `LOCK_N`, go to LOCKED and clear `good`.
  - Otherwise clear `good`.
  - SYNC never pulses `oErr`; a bad segment still sets `oSegErr`.
- **LOCKED**, first matching rule wins:
  1. `seg_ok && seq_ok`: stay. If `prev == 7`, `oWrapCnt` increments.
  2. `seg_ok && iQ == 0 && !seq_ok`: treated as a legitimate counter reset. Pulse `oResync`, stay, no error.
  3. Otherwise: pulse `oErr`, increment `oErrCnt` (saturating), clear `good`, go to SYNC.
- **Segment errors:** `oSegErr` is set on any cycle with `!seg_ok`, in either state.

## Timing
- **Reset:** with `rst` high at an edge, the block is cleared as follows:
  - State is SYNC; `good`, `prev` and `prev_valid` are 0.
  - All outputs are 0.
  - The first edge after reset only loads `prev`; no sequence check is possible on it.
- **Latency:** all outputs are registered. The effect of inputs sampled at edge k is visible after edge k.
  - `oErr` and `oResync` are high for exactly the one cycle after edge k.
  - `oErrCnt` and `oWrapCnt` update at edge k.
  - `oLocked` rises at the edge on which the `LOCK_N`-th good increment is sampled.
- **Minimum lock time** after reset with a clean count: 1 + `LOCK_N` edges (3 with the default).
- **Simultaneous events:**
  - A bad segment together with a wrong sequence produces one `oErr` and one count increment.
  - A wrap (7→0) is always `seq_ok`, so it is never reported as a resync.
- **Reset mid-operation:** `rst` clears the counters and the sticky flag on the same edge. Any pulse pending from that edge is suppressed.
- **Saturation:** `oErrCnt` holds at 2^ERR_W − 1 and does not wrap.

## Test plan
- **Clean count:** `rst` for 1 edge, then `iQ` 0,1,2,… with matching patterns 40,79,24,… →
  - `oLocked` = 1 after the 3rd post-reset edge.
  - `oErr` never asserts.
  - `oWrapCnt` = 1 after the first 7→0 and = 2 after the second.
- **Counter reset mid-count:** while locked, the sequence 3,4,5,0,1 with correct patterns →
  - `oResync` pulses once, after the edge sampling 0.
  - `oLocked` stays 1; `oErrCnt` stays 0.
- **Skipped count:** while locked, the sequence 2,3,5 →
  - `oErr` pulses once and `oErrCnt` = 1.
  - `oLocked` drops to 0, then returns after 6,7 (`LOCK_N` = 2 good increments).
- **Segment mismatch:** while locked, `iQ` = 4 with pattern 12 (which decodes to 5) →
  - `oErr` pulses and `oSegErr` = 1.
  - `oSegErr` remains 1 through later clean counting until `rst`.
- **Invalid pattern and saturation:** with `ERR_W` = 2, inject 5 errors with pattern 7F →
  - `oErrCnt` reaches 3 and holds there.
  - `rst` then clears `oErrCnt`, `oSegErr` and `oLocked` to 0 on the same edge.
